pulse_interval_rx: RTL and testbench

Parametrised pulse-interval receiver for the optical link: recovers packets from the limiting-amplifier output by measuring clock cycles between successive rising edges. Adds input synchronisation, glitch/timeout/parity error detection and a valid/ready output buffer, so the receive path can feed the packet layer without losing packets silently. Sits between the limiting-amplifier input pin and the packet-layer consumer.

---
 rtl/pulse_interval_rx.sv | 159 +++++++++++++++
 tb/tb_pulse_interval_rx.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_interval_rx.sv
// Pulse-interval receiver: decodes packets from the spacing between rising edges on an
// asynchronous line and hands them to a consumer through a one-entry valid/ready buffer.
module pulse_interval_rx #(
  parameter int unsigned PACKET_SIZE   = 8,
  parameter int unsigned COUNTER_SIZE  = 8,
  parameter int unsigned INTERVAL_LOW  = 4,
  parameter int unsigned INTERVAL_HIGH = 8,
  parameter int unsigned TIMEOUT       = 16,
  parameter int unsigned PARITY_EN     = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   signal,
  input  logic                   ready,
  output logic [PACKET_SIZE-1:0] data,
  output logic                   valid,
  output logic                   busy,
  output logic                   err_glitch,
  output logic                   err_timeout,
  output logic                   err_parity,
  output logic                   overrun
);

  localparam int unsigned NumBits = PACKET_SIZE + PARITY_EN;
  localparam int unsigned IdxW    = (NumBits > 1) ? $clog2(NumBits) : 1;

  localparam logic [COUNTER_SIZE-1:0] LowCnt     = COUNTER_SIZE'(INTERVAL_LOW);
  localparam logic [COUNTER_SIZE-1:0] HighCnt    = COUNTER_SIZE'(INTERVAL_HIGH);
  localparam logic [COUNTER_SIZE-1:0] TimeoutCnt = COUNTER_SIZE'(TIMEOUT);
  localparam logic [IdxW-1:0]         LastIdx    = IdxW'(NumBits - 1);

  typedef enum logic [0:0] {StIdle, StReceive} state_e;

  state_e                  state_q, state_d;
  logic                    sync1_q, sync2_q, delay_q;
  logic                    rise;
  logic [COUNTER_SIZE-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [NumBits-1:0]      shreg_q, shreg_d;
  logic [NumBits-1:0]      bits_new;
  logic                    parity_bad;
  logic [PACKET_SIZE-1:0]  data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    glitch_q, glitch_d;
  logic                    timeout_q, timeout_d;
  logic                    parity_q, parity_d;
  logic                    overrun_q, overrun_d;

  assign rise = sync2_q & ~delay_q;

  // Interval counter: loads 1 on every edge, saturates so it can never wrap back below TIMEOUT.
  always_comb begin
    cnt_d = cnt_q;
    if (rise) begin
      cnt_d = COUNTER_SIZE'(1);
    end else if (cnt_q != TimeoutCnt) begin
      cnt_d = cnt_q + COUNTER_SIZE'(1);
    end
  end

  // Shift register contents if the current edge is accepted as the next bit.
  always_comb begin
    bits_new        = shreg_q;
    bits_new[idx_q] = (cnt_q >= HighCnt);
    parity_bad      = (PARITY_EN != 0) &&
                      ((^bits_new[PACKET_SIZE-1:0]) != bits_new[NumBits-1]);
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    valid_d   = valid_q & ~ready;
    glitch_d  = 1'b0;
    timeout_d = 1'b0;
    parity_d  = 1'b0;
    overrun_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rise) begin
          state_d = StReceive;
          idx_d   = '0;
          shreg_d = '0;
        end
      end
      StReceive: begin
        // Timeout wins over an edge arriving in the same cycle.
        if (cnt_q == TimeoutCnt) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
        end else if (rise) begin
          if (cnt_q < LowCnt) begin
            glitch_d = 1'b1;
            state_d  = StIdle;
          end else begin
            shreg_d = bits_new;
            if (idx_q == LastIdx) begin
              state_d = StIdle;
              if (parity_bad) begin
                parity_d = 1'b1;
              end else if (!valid_q || ready) begin
                data_d  = bits_new[PACKET_SIZE-1:0];
                valid_d = 1'b1;
              end else begin
                overrun_d = 1'b1;
              end
            end else begin
              idx_d = idx_q + IdxW'(1);
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      delay_q   <= 1'b0;
      cnt_q     <= '0;
      idx_q     <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      glitch_q  <= 1'b0;
      timeout_q <= 1'b0;
      parity_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= signal;
      sync2_q   <= sync1_q;
      delay_q   <= sync2_q;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      glitch_q  <= glitch_d;
      timeout_q <= timeout_d;
      parity_q  <= parity_d;
      overrun_q <= overrun_d;
    end
  end

  assign data        = data_q;
  assign valid       = valid_q;
  assign busy        = (state_q == StReceive);
  assign err_glitch  = glitch_q;
  assign err_timeout = timeout_q;
  assign err_parity  = parity_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_pulse_interval_rx.sv
// Bench for pulse_interval_rx: default instance plus a parity-enabled instance; expected
// packets are queued as they are sent and popped when the receiver presents them.
module tb_pulse_interval_rx;

  logic       clock;
  logic       reset;
  logic       sig;
  logic       sel_p;
  logic       ready;
  logic       line_a, line_p;
  logic [7:0] data, data_p;
  logic       valid, valid_p, busy, busy_p;
  logic       err_glitch, err_timeout, err_parity, overrun;
  logic       err_glitch_p, err_timeout_p, err_parity_p, overrun_p;

  int n_checks = 0;
  int n_fail   = 0;
  int n_glitch = 0;
  int n_timeout = 0;
  int n_parity = 0;
  int n_overrun = 0;
  int n_multi  = 0;

  logic [7:0] exp_q[$];

  assign line_a = sel_p ? 1'b0 : sig;
  assign line_p = sel_p ? sig : 1'b0;

  pulse_interval_rx dut (
    .clock(clock), .reset(reset), .signal(line_a), .ready(ready), .data(data),
    .valid(valid), .busy(busy), .err_glitch(err_glitch), .err_timeout(err_timeout),
    .err_parity(err_parity), .overrun(overrun)
  );

  pulse_interval_rx #(.PARITY_EN(1)) dut_p (
    .clock(clock), .reset(reset), .signal(line_p), .ready(ready), .data(data_p),
    .valid(valid_p), .busy(busy_p), .err_glitch(err_glitch_p), .err_timeout(err_timeout_p),
    .err_parity(err_parity_p), .overrun(overrun_p)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    n_glitch  <= n_glitch + int'(err_glitch) + int'(err_glitch_p);
    n_timeout <= n_timeout + int'(err_timeout) + int'(err_timeout_p);
    n_parity  <= n_parity + int'(err_parity) + int'(err_parity_p);
    n_overrun <= n_overrun + int'(overrun) + int'(overrun_p);
    if ($countones({err_glitch, err_timeout, err_parity, overrun}) > 1 ||
        $countones({err_glitch_p, err_timeout_p, err_parity_p, overrun_p}) > 1)
      n_multi <= n_multi + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One rising edge on the line; returns one cycle after the rise.
  task automatic pulse();
    @(posedge clock); #1 sig = 1'b1;
    @(posedge clock); #1 sig = 1'b0;
  endtask

  task automatic gap_pulse(input int gap);
    repeat (gap - 2) @(posedge clock);
    pulse();
  endtask

  task automatic send_bits(input logic [8:0] bits, input int nbits, input int zg, input int og);
    pulse();
    for (int i = 0; i < nbits; i++) gap_pulse(bits[i] ? og : zg);
  endtask

  task automatic wait_valid(input bit on_p, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (on_p ? valid_p : valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic consume();
    @(posedge clock); #1 ready = 1'b1;
    @(posedge clock); #1 ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; ready = 1'b0; sig = 1'b0; sel_p = 1'b0;
    #12;
    n_checks++;
    if (data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", data); end
    n_checks++;
    if ({valid, valid_p} !== 2'b00) begin
      n_fail++; $display("FAIL reset_valid: got %b want 00", {valid, valid_p});
    end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++;
    if ({err_glitch, err_timeout, err_parity, overrun} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_errs: got %b want 0000",
               {err_glitch, err_timeout, err_parity, overrun});
    end
    @(negedge clock); reset = 1'b1;
    repeat (3) @(posedge clock);
  endtask

  task automatic test_basic();
    logic [7:0] exp;
    send_bits(9'h08D, 8, 4, 8);
    exp_q.push_back(8'h8D);
    @(posedge clock); @(negedge clock);
    n_checks++;
    if (valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b want 0", valid); end
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b want 1", busy); end
    @(posedge clock); @(negedge clock);
    n_checks++;
    if (valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", valid); end
    exp = exp_q.pop_front();
    n_checks++;
    if (data !== exp) begin n_fail++; $display("FAIL basic_data: got %h want %h", data, exp); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle: got %b want 0", busy); end
    consume();
    @(negedge clock);
    n_checks++;
    if (valid !== 1'b0) begin n_fail++; $display("FAIL basic_consume: got %b want 0", valid); end
  endtask

  task automatic test_boundary();
    logic [7:0] exp;
    bit ok;
    send_bits(9'h0A5, 8, 7, 15);
    exp_q.push_back(8'hA5);
    wait_valid(1'b0, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL boundary_valid: got 0 want 1"); end
    exp = exp_q.pop_front();
    n_checks++;
    if (data !== exp) begin n_fail++; $display("FAIL boundary_data: got %h want %h", data, exp); end
    consume();
  endtask

  task automatic test_glitch();
    int g0;
    logic [7:0] exp;
    bit ok;
    g0 = n_glitch;
    pulse();
    gap_pulse(8);
    @(negedge clock);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_pre: got %b want 1", busy); end
    gap_pulse(4);
    gap_pulse(2);
    repeat (10) @(negedge clock);
    n_checks++;
    if (n_glitch - g0 !== 1) begin
      n_fail++; $display("FAIL glitch_count: got %0d want 1", n_glitch - g0);
    end
    n_checks++;
    if ({valid, busy} !== 2'b00) begin
      n_fail++; $display("FAIL glitch_state: got valid,busy=%b want 00", {valid, busy});
    end
    send_bits(9'h03C, 8, 4, 8);
    exp_q.push_back(8'h3C);
    wait_valid(1'b0, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL glitch_recover_valid: got 0 want 1"); end
    exp = exp_q.pop_front();
    n_checks++;
    if (data !== exp) begin n_fail++; $display("FAIL glitch_recover: got %h want %h", data, exp); end
    consume();
  endtask

  task automatic test_timeout();
    int t0;
    t0 = n_timeout;
    pulse();
    repeat (17) @(posedge clock);
    @(negedge clock);
    n_checks++;
    if ({err_timeout, busy} !== 2'b01) begin
      n_fail++; $display("FAIL timeout_early: got err,busy=%b want 01", {err_timeout, busy});
    end
    @(posedge clock); @(negedge clock);
    n_checks++;
    if ({err_timeout, busy} !== 2'b10) begin
      n_fail++; $display("FAIL timeout_pulse: got err,busy=%b want 10", {err_timeout, busy});
    end
    repeat (20) @(negedge clock);
    n_checks++;
    if (n_timeout - t0 !== 1) begin
      n_fail++; $display("FAIL timeout_count: got %0d want 1", n_timeout - t0);
    end
    n_checks++;
    if (valid !== 1'b0) begin n_fail++; $display("FAIL timeout_valid: got %b want 0", valid); end
  endtask

  task automatic test_parity();
    int p0;
    logic par;
    logic [7:0] exp;
    bit ok;
    sel_p = 1'b1;
    p0 = n_parity;
    send_bits({1'b0, 8'h01}, 9, 4, 8);
    repeat (10) @(negedge clock);
    n_checks++;
    if (n_parity - p0 !== 1) begin
      n_fail++; $display("FAIL parity_count: got %0d want 1", n_parity - p0);
    end
    n_checks++;
    if (valid_p !== 1'b0) begin n_fail++; $display("FAIL parity_valid: got %b want 0", valid_p); end
    par = ^8'h01;
    send_bits({par, 8'h01}, 9, 4, 8);
    exp_q.push_back(8'h01);
    wait_valid(1'b1, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL parity_good_valid: got 0 want 1"); end
    exp = exp_q.pop_front();
    n_checks++;
    if (data_p !== exp) begin
      n_fail++; $display("FAIL parity_good_data: got %h want %h", data_p, exp);
    end
    n_checks++;
    if (n_parity - p0 !== 1) begin
      n_fail++; $display("FAIL parity_good_count: got %0d want 1", n_parity - p0);
    end
    consume();
    n_checks++;
    if (busy_p !== 1'b0) begin n_fail++; $display("FAIL parity_busy: got %b want 0", busy_p); end
    sel_p = 1'b0;
  endtask

  task automatic test_back_to_back();
    int o0;
    logic [7:0] exp;
    o0 = n_overrun;
    send_bits(9'h05A, 8, 4, 8);
    exp_q.push_back(8'h5A);
    send_bits(9'h0C3, 8, 4, 8);
    repeat (10) @(negedge clock);
    n_checks++;
    if (n_overrun - o0 !== 1) begin
      n_fail++; $display("FAIL b2b_overrun: got %0d want 1", n_overrun - o0);
    end
    exp = exp_q.pop_front();
    n_checks++;
    if ({valid, data} !== {1'b1, exp}) begin
      n_fail++; $display("FAIL b2b_retained: got %b/%h want 1/%h", valid, data, exp);
    end
    send_bits(9'h096, 8, 4, 8);
    exp_q.push_back(8'h96);
    @(posedge clock); #1 ready = 1'b1;
    @(posedge clock); #1 ready = 1'b0;
    @(negedge clock);
    exp = exp_q.pop_front();
    n_checks++;
    if ({valid, data} !== {1'b1, exp}) begin
      n_fail++; $display("FAIL b2b_replace: got %b/%h want 1/%h", valid, data, exp);
    end
    repeat (3) @(negedge clock);
    n_checks++;
    if (n_overrun - o0 !== 1) begin
      n_fail++; $display("FAIL b2b_no_overrun: got %0d want 1", n_overrun - o0);
    end
    consume();
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp;
    bit ok;
    send_bits(9'h011, 8, 4, 8);
    exp_q.push_back(8'h11);
    wait_valid(1'b0, ok);
    exp = exp_q.pop_front();
    n_checks++;
    if (!ok || data !== exp) begin
      n_fail++; $display("FAIL rstmid_pre: got %b/%h want 1/%h", ok, data, exp);
    end
    pulse();
    gap_pulse(8);
    gap_pulse(4);
    #3 reset = 1'b0;
    #1;
    n_checks++;
    if ({valid, busy, data} !== 10'h000) begin
      n_fail++; $display("FAIL rstmid_async: got %b/%b/%h want 0/0/00", valid, busy, data);
    end
    @(negedge clock); reset = 1'b1;
    repeat (2) @(posedge clock);
    send_bits(9'h0E7, 8, 4, 8);
    exp_q.push_back(8'hE7);
    wait_valid(1'b0, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL rstmid_after_valid: got 0 want 1"); end
    exp = exp_q.pop_front();
    n_checks++;
    if (data !== exp) begin n_fail++; $display("FAIL rstmid_after: got %h want %h", data, exp); end
    consume();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_glitch();
    test_timeout();
    test_parity();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clock);
    n_checks++;
    if (n_multi !== 0) begin
      n_fail++; $display("FAIL err_exclusive: got %0d cycles want 0", n_multi);
    end
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
